// File: rtl/sev_seg_decoder.sv
// Purpose : receive-side decoder for a multiplexed, active-low 7-segment display bus.
//           It waits for each anode/cathode pattern to settle, then decodes it back to a
//           hex nibble, a decimal-point bit and a blank flag, and reassembles the 8-digit frame.
// Latency : SETTLE_CYCLES+1 edges from the pins to DIGITS/DP/BLANK/SEEN/ERR; FRAME_VALID
//           rises on the same edge as the completing sample.
// Backpr. : none; this is a passive monitor, and patterns that never settle are ignored.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous reset, active-high
//   SSEG_CA[7:0] cathodes, active-low: [6:0] = segments a..g, [7] = decimal point
//   SSEG_AN[7:0] anodes, active-low: bit i selects digit i
//   ERR_CLR      clears the sticky ERR flag; a new error on the same edge wins
//   DIGITS[31:0] decoded nibbles; digit i sits at [4i+3:4i]
//   DP[7:0]      decimal point lit on digit i
//   BLANK[7:0]   digit i was last seen with all segments off
//   SEEN[7:0]    digits captured so far in the current, incomplete frame
//   FRAME_VALID  one-cycle pulse when all 8 digits have been captured
//   ERR          sticky protocol/pattern error
module sev_seg_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4   // legal range 1..15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  SSEG_CA,
    input  logic [7:0]  SSEG_AN,
    input  logic        ERR_CLR,
    output logic [31:0] DIGITS,
    output logic [7:0]  DP,
    output logic [7:0]  BLANK,
    output logic [7:0]  SEEN,
    output logic        FRAME_VALID,
    output logic        ERR
);

    localparam logic [3:0] SETTLE    = SETTLE_CYCLES[3:0];
    localparam logic [3:0] SETTLE_M1 = SETTLE - 4'd1;

    // Returns {legal, nibble}. An all-off pattern (7F) is not a legal hex pattern here;
    // the caller handles blanks separately.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // State registers
    logic [15:0] r_in_q;
    logic [3:0]  cnt_q,    cnt_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  dp_q,     dp_d;
    logic [7:0]  blank_q,  blank_d;
    logic [7:0]  seen_q,   seen_d;
    logic        fv_q,     fv_d;
    logic        err_q,    err_d;

    // Combinational helpers
    logic [15:0] pins;
    logic        pin_change;
    logic        sample;
    logic [7:0]  an_low;
    logic [7:0]  ca;
    logic        an_one;
    logic        an_multi;
    logic [2:0]  idx;
    logic [4:0]  dec;
    logic [7:0]  seen_set;
    logic        new_err;
    logic        upd;

    assign pins       = {SSEG_AN, SSEG_CA};
    assign pin_change = (pins != r_in_q);

    // Sample exactly on the edge where the counter reaches SETTLE, i.e. when it is one
    // short of SETTLE and the pins still match r_in; a saturated counter never re-samples.
    assign sample = !pin_change && (cnt_q == SETTLE_M1);

    always_comb begin
        cnt_d = cnt_q;
        if (pin_change) begin
            cnt_d = 4'd0;
        end else if (cnt_q != SETTLE) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Decode the settled pattern held in r_in (not the raw pins).
    assign an_low   = ~r_in_q[15:8];
    assign ca       = r_in_q[7:0];
    assign an_one   = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
    assign an_multi = (an_low != 8'h00) && !an_one;
    assign dec      = seg_decode(ca[6:0]);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign seen_set = seen_q | (8'b1 << idx);

    always_comb begin
        digits_d = digits_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        seen_d   = seen_q;
        fv_d     = 1'b0;
        new_err  = 1'b0;
        upd      = 1'b0;

        if (sample) begin
            if (an_multi) begin
                new_err = 1'b1;
            end else if (an_one) begin
                if (dec[4]) begin
                    digits_d[{idx, 2'b00} +: 4] = dec[3:0];
                    blank_d[idx]                = 1'b0;
                    dp_d[idx]                   = ~ca[7];
                    upd                         = 1'b1;
                end else if (ca[6:0] == 7'h7F) begin
                    // Blank digit: keep the last nibble, only flag it as blank.
                    blank_d[idx] = 1'b1;
                    dp_d[idx]    = ~ca[7];
                    upd          = 1'b1;
                end else begin
                    new_err = 1'b1;
                end

                if (upd) begin
                    // seen_set can only reach FF when this sample adds the last missing
                    // digit, so re-sampling a digit never completes a frame.
                    if (seen_set == 8'hFF) begin
                        seen_d = 8'h00;
                        fv_d   = 1'b1;
                    end else begin
                        seen_d = seen_set;
                    end
                end
            end
        end

        // A new error takes priority over a simultaneous clear.
        err_d = new_err | (err_q & ~ERR_CLR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_in_q   <= 16'hFFFF;
            cnt_q    <= 4'd0;
            digits_q <= 32'h0;
            dp_q     <= 8'h00;
            blank_q  <= 8'h00;
            seen_q   <= 8'h00;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            r_in_q   <= pins;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            seen_q   <= seen_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign DIGITS      = digits_q;
    assign DP          = dp_q;
    assign BLANK       = blank_q;
    assign SEEN        = seen_q;
    assign FRAME_VALID = fv_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_sev_seg_decoder.sv
// Purpose : directed self-checking bench for sev_seg_decoder (SETTLE_CYCLES = 4).
// Latency : inputs change 1 time unit after a rising edge; outputs are read 1 unit after.
// Backpr. : not applicable.
module tb_sev_seg_decoder;

    logic        CLK;
    logic        RST;
    logic [7:0]  SSEG_CA;
    logic [7:0]  SSEG_AN;
    logic        ERR_CLR;
    logic [31:0] DIGITS;
    logic [7:0]  DP;
    logic [7:0]  BLANK;
    logic [7:0]  SEEN;
    logic        FRAME_VALID;
    logic        ERR;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int fv_base;

    // Segment codes with the decimal point off (bit 7 high).
    logic [7:0] ca_code [1:8];

    sev_seg_decoder #(.SETTLE_CYCLES(4)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SSEG_CA     (SSEG_CA),
        .SSEG_AN     (SSEG_AN),
        .ERR_CLR     (ERR_CLR),
        .DIGITS      (DIGITS),
        .DP          (DP),
        .BLANK       (BLANK),
        .SEEN        (SEEN),
        .FRAME_VALID (FRAME_VALID),
        .ERR         (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FRAME_VALID === 1'b1) fv_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a pattern and let n rising edges pass; returns 1 unit after the last edge.
    task automatic hold(input logic [7:0] an, input logic [7:0] ca, input int n);
        SSEG_AN = an;
        SSEG_CA = ca;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        ca_code[1] = 8'hF9; ca_code[2] = 8'hA4; ca_code[3] = 8'hB0; ca_code[4] = 8'h99;
        ca_code[5] = 8'h92; ca_code[6] = 8'h82; ca_code[7] = 8'hF8; ca_code[8] = 8'h80;

        // ---------------- reset under random activity ----------------
        RST = 1'b1; ERR_CLR = 1'b0; SSEG_AN = 8'hFF; SSEG_CA = 8'hFF;
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 6; i++) begin
            SSEG_AN = 8'($urandom);
            SSEG_CA = 8'($urandom);
            ERR_CLR = 1'($urandom);
            @(posedge CLK);
            #1;
            chk("rst_digits", {32'h0, DIGITS}, 64'h0);
            chk("rst_flags", {35'h0, DP, BLANK, SEEN, FRAME_VALID, ERR}, 64'h0);
        end
        SSEG_AN = 8'hFF; SSEG_CA = 8'hFF; ERR_CLR = 1'b0;
        RST = 1'b0;
        hold(8'hFF, 8'hFF, 20);
        chk("idle_digits", {32'h0, DIGITS}, 64'h0);
        chk("idle_flags", {35'h0, DP, BLANK, SEEN, FRAME_VALID, ERR}, 64'h0);

        // ---------------- single digit, sample latency ----------------
        hold(8'hFE, 8'hC0, 4);
        chk("pre_sample_seen", {56'h0, SEEN}, 64'h00);
        hold(8'hFE, 8'hC0, 1);
        chk("d0_seen", {56'h0, SEEN}, 64'h01);
        chk("d0_nib", {60'h0, DIGITS[3:0]}, 64'h0);
        chk("d0_dp", {63'h0, DP[0]}, 64'h0);
        hold(8'hFE, 8'hC0, 1);
        hold(8'hFE, 8'h79, 6);
        chk("d0_one", {32'h0, DIGITS}, 64'h1);
        chk("d0_one_dp", {56'h0, DP}, 64'h01);
        chk("d0_one_seen", {56'h0, SEEN}, 64'h01);

        // ---------------- glitch rejection ----------------
        hold(8'hFD, 8'h24, 4);
        hold(8'hFF, 8'hFF, 2);
        chk("glitch_digits", {32'h0, DIGITS}, 64'h1);
        chk("glitch_seen", {56'h0, SEEN}, 64'h01);
        hold(8'hFD, 8'h24, 5);
        chk("d1_digits", {32'h0, DIGITS}, 64'h21);
        chk("d1_seen", {56'h0, SEEN}, 64'h03);
        chk("d1_dp", {56'h0, DP}, 64'h03);

        // ---------------- full frame ----------------
        fv_base = fv_cnt;
        for (int d = 0; d < 7; d++) begin
            hold(~(8'h01 << d), ca_code[d + 1], 8);
            chk("frame_no_fv", {63'h0, FRAME_VALID}, 64'h0);
        end
        hold(8'h7F, 8'h00, 5);
        chk("frame_fv", {63'h0, FRAME_VALID}, 64'h1);
        chk("frame_digits", {32'h0, DIGITS}, 64'h87654321);
        chk("frame_dp", {56'h0, DP}, 64'h80);
        chk("frame_blank", {56'h0, BLANK}, 64'h00);
        chk("frame_seen", {56'h0, SEEN}, 64'h00);
        hold(8'h7F, 8'h00, 3);
        chk("frame_fv_drop", {63'h0, FRAME_VALID}, 64'h0);
        chk("frame_fv_count", 64'(fv_cnt - fv_base), 64'h1);

        // ---------------- errors ----------------
        hold(8'hFC, 8'hC0, 5);
        chk("multi_an_err", {63'h0, ERR}, 64'h1);
        chk("multi_an_digits", {32'h0, DIGITS}, 64'h87654321);
        chk("multi_an_seen", {56'h0, SEEN}, 64'h00);
        ERR_CLR = 1'b1;
        hold(8'hFC, 8'hC0, 1);
        ERR_CLR = 1'b0;
        hold(8'hFC, 8'hC0, 10);
        chk("clr_and_long_hold", {63'h0, ERR}, 64'h0);
        hold(8'hFE, 8'hF9, 5);
        chk("pre_bad_seen", {56'h0, SEEN}, 64'h01);
        hold(8'hFE, 8'hFE, 5);
        chk("bad_ca_err", {63'h0, ERR}, 64'h1);
        chk("bad_ca_seen", {56'h0, SEEN}, 64'h01);
        chk("bad_ca_digits", {32'h0, DIGITS}, 64'h87654321);
        ERR_CLR = 1'b1;
        hold(8'hFF, 8'hFF, 1);
        ERR_CLR = 1'b0;
        chk("clr_alone", {63'h0, ERR}, 64'h0);
        hold(8'hFC, 8'hC0, 4);
        ERR_CLR = 1'b1;
        hold(8'hFC, 8'hC0, 1);
        ERR_CLR = 1'b0;
        hold(8'hFF, 8'hFF, 2);
        chk("set_beats_clr", {63'h0, ERR}, 64'h1);
        ERR_CLR = 1'b1;
        hold(8'hFF, 8'hFF, 1);
        ERR_CLR = 1'b0;

        // ---------------- blank digit ----------------
        hold(8'hFB, 8'h7F, 5);
        chk("blank_flag", {56'h0, BLANK}, 64'h04);
        chk("blank_dp", {56'h0, DP}, 64'h84);
        chk("blank_seen", {56'h0, SEEN}, 64'h05);
        chk("blank_digits", {32'h0, DIGITS}, 64'h87654321);
        hold(8'hFB, 8'h99, 5);
        chk("unblank_flag", {56'h0, BLANK}, 64'h00);
        chk("unblank_digits", {32'h0, DIGITS}, 64'h87654421);
        chk("unblank_dp", {56'h0, DP}, 64'h80);
        chk("resample_no_fv", {56'h0, SEEN}, 64'h05);

        // ---------------- reset mid-frame ----------------
        fv_base = fv_cnt;
        for (int d = 0; d < 6; d++) begin
            hold(~(8'h01 << d), 8'hA4, 5);
        end
        chk("mid_seen", {56'h0, SEEN}, 64'h3F);
        chk("mid_digits", {32'h0, DIGITS}, 64'h87222222);
        SSEG_AN = 8'hFF; SSEG_CA = 8'hFF;
        RST = 1'b1;
        #2;
        chk("async_rst_seen", {56'h0, SEEN}, 64'h00);
        chk("async_rst_digits", {32'h0, DIGITS}, 64'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        hold(8'hBF, 8'hF9, 5);
        hold(8'h7F, 8'hF9, 5);
        chk("post_rst_seen", {56'h0, SEEN}, 64'hC0);
        chk("post_rst_digits", {32'h0, DIGITS}, 64'h11000000);
        hold(8'hFF, 8'hFF, 3);
        chk("post_rst_no_fv", 64'(fv_cnt - fv_base), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
